// File: rtl/glyph_row_serializer_pkg.sv
// Shared font geometry and the glyph-row slicing helper for the glyph row serializer.
package glyph_row_serializer_pkg;

  localparam int unsigned CHAR_BITS  = 7;
  localparam int unsigned FONT_W     = 8;
  localparam int unsigned FONT_H     = 16;
  localparam int unsigned GLYPH_BITS = FONT_W * FONT_H;
  localparam int unsigned ROW_BITS   = 4;
  localparam int unsigned CNT_BITS   = $clog2(FONT_W);
  localparam int unsigned IDX_BITS   = $clog2(GLYPH_BITS);

  typedef logic [FONT_W-1:0] row_byte_t;

  // Glyph bit 0 is the top-left pixel; the leftmost pixel of a row lands in the byte MSB.
  function automatic row_byte_t row_slice(input logic [0:GLYPH_BITS-1] glyph,
                                          input logic [ROW_BITS-1:0]   row);
    logic [IDX_BITS-1:0] base;
    row_byte_t           b;
    base = IDX_BITS'(FONT_W * 32'(row));
    b    = '0;
    if (32'(row) < FONT_H) begin
      b = glyph[base +: FONT_W];
    end
    return b;
  endfunction

endpackage

// File: rtl/glyph_row_serializer_if.sv
// Request and pixel-stream handshakes between a cell requester/pixel sink and the serializer.
interface glyph_row_serializer_if;
  import glyph_row_serializer_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [CHAR_BITS-1:0] req_char;
  logic [ROW_BITS-1:0]  req_row;
  logic                 pix_valid;
  logic                 pix_ready;
  logic                 pix;
  logic                 last;

  modport master (
    output req_valid, req_char, req_row, pix_ready,
    input  req_ready, pix_valid, pix, last
  );

  modport slave (
    input  req_valid, req_char, req_row, pix_ready,
    output req_ready, pix_valid, pix, last
  );

endinterface

// File: rtl/glyph_row_serializer_row_mux.sv
// Combinational selection of one glyph row byte, blanking rows beyond the font height.
module glyph_row_serializer_row_mux
  import glyph_row_serializer_pkg::*;
(
  input  logic [0:GLYPH_BITS-1] font_data_i,
  input  logic [ROW_BITS-1:0]   row_i,
  output row_byte_t             byte_o
);

  always_comb begin
    byte_o = row_slice(font_data_i, row_i);
  end

endmodule

// File: rtl/glyph_row_serializer.sv
// Font ROM reader that fetches one glyph row per request and streams it out MSB-first,
// double-buffered so back-to-back cells stream without a bubble.
module glyph_row_serializer
  import glyph_row_serializer_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rstn_i,
  glyph_row_serializer_if.slave bus_if,
  output logic [CHAR_BITS-1:0]  font_addr_o,
  input  logic [0:GLYPH_BITS-1] font_data_i,
  output logic                  busy_o
);

  logic                 pend_a_q, pend_a_d;
  logic                 pend_b_q, pend_b_d;
  logic [CHAR_BITS-1:0] addr_q, addr_d;
  logic [ROW_BITS-1:0]  row_q, row_d;
  row_byte_t            nxt_q, nxt_d;
  logic                 nxt_valid_q, nxt_valid_d;
  row_byte_t            sh_q, sh_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic                 pv_q, pv_d;

  row_byte_t            fetched_byte;
  logic                 accept;
  logic                 fire;
  logic                 finishing;
  logic                 shifter_free;

  glyph_row_serializer_row_mux u_row_mux (
    .font_data_i (font_data_i),
    .row_i       (row_q),
    .byte_o      (fetched_byte)
  );

  assign bus_if.req_ready = ~pend_a_q & ~pend_b_q & ~nxt_valid_q;
  assign accept           = bus_if.req_valid & bus_if.req_ready;
  assign fire             = pv_q & bus_if.pix_ready;
  assign finishing        = fire & (cnt_q == CNT_BITS'(FONT_W - 1));
  assign shifter_free     = ~pv_q | finishing;

  // Fetch pipe: pend_a covers the ROM address cycle, pend_b the ROM data cycle.
  always_comb begin
    addr_d   = addr_q;
    row_d    = row_q;
    pend_a_d = accept;
    pend_b_d = pend_a_q;
    if (accept) begin
      addr_d = bus_if.req_char;
      row_d  = bus_if.req_row;
    end
  end

  always_comb begin
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    pv_d        = pv_q;
    nxt_d       = nxt_q;
    nxt_valid_d = nxt_valid_q;

    if (fire) begin
      sh_d  = sh_q << 1;
      cnt_d = cnt_q + 1'b1;
    end

    if (shifter_free) begin
      if (nxt_valid_q) begin
        sh_d        = nxt_q;
        cnt_d       = '0;
        pv_d        = 1'b1;
        nxt_valid_d = 1'b0;
        if (pend_b_q) begin
          nxt_d       = fetched_byte;
          nxt_valid_d = 1'b1;
        end
      end else if (pend_b_q) begin
        sh_d  = fetched_byte;
        cnt_d = '0;
        pv_d  = 1'b1;
      end else if (finishing) begin
        pv_d = 1'b0;
      end
    end else if (pend_b_q) begin
      nxt_d       = fetched_byte;
      nxt_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pend_a_q    <= 1'b0;
      pend_b_q    <= 1'b0;
      addr_q      <= '0;
      row_q       <= '0;
      nxt_q       <= '0;
      nxt_valid_q <= 1'b0;
      sh_q        <= '0;
      cnt_q       <= '0;
      pv_q        <= 1'b0;
    end else begin
      pend_a_q    <= pend_a_d;
      pend_b_q    <= pend_b_d;
      addr_q      <= addr_d;
      row_q       <= row_d;
      nxt_q       <= nxt_d;
      nxt_valid_q <= nxt_valid_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      pv_q        <= pv_d;
    end
  end

  assign font_addr_o      = addr_q;
  assign bus_if.pix_valid = pv_q;
  assign bus_if.pix       = sh_q[FONT_W-1];
  assign bus_if.last      = pv_q & (cnt_q == CNT_BITS'(FONT_W - 1));
  assign busy_o           = pend_a_q | pend_b_q | nxt_valid_q | pv_q;

endmodule

// File: tb/tb_glyph_row_serializer.sv
// Directed bench for glyph_row_serializer with a behavioural 1-cycle font ROM.
module tb_glyph_row_serializer;

  logic         clk;
  logic         rstn;
  logic [6:0]   font_addr;
  logic [0:127] font_data;
  logic         busy;
  int           errors;
  int           checks;

  glyph_row_serializer_if bus ();

  glyph_row_serializer dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .bus_if      (bus),
    .font_addr_o (font_addr),
    .font_data_i (font_data),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Test font: hand-drawn rows for 'A', a simple hash for every other code.
  function automatic logic [7:0] rom_byte(input logic [6:0] c, input logic [3:0] r);
    logic [7:0] b;
    if (c == 7'h41) begin
      case (r)
        4'd0:    b = 8'hC3;
        4'd1:    b = 8'h18;
        4'd2:    b = 8'h3C;
        4'd3:    b = 8'h66;
        4'd4:    b = 8'h66;
        4'd5:    b = 8'h7E;
        4'd6:    b = 8'h66;
        4'd7:    b = 8'h66;
        4'd8:    b = 8'h66;
        4'd9:    b = 8'h66;
        4'd10:   b = 8'h81;
        4'd11:   b = 8'h5A;
        4'd12:   b = 8'hA5;
        4'd13:   b = 8'h0F;
        4'd14:   b = 8'hF0;
        default: b = 8'hFF;
      endcase
    end else begin
      b = (({1'b0, c} * 8'd29) ^ {r, r}) + 8'h3C;
    end
    return b;
  endfunction

  function automatic logic [0:127] glyph(input logic [6:0] c);
    logic [0:127] g;
    logic [7:0]   b;
    for (int r = 0; r < 16; r++) begin
      b = rom_byte(c, 4'(r));
      for (int k = 0; k < 8; k++) g[8*r+k] = b[7-k];
    end
    return g;
  endfunction

  function automatic logic exp_pix(input logic [6:0] c, input logic [3:0] r, input int i);
    logic [7:0] b;
    b = rom_byte(c, r);
    return b[7-i];
  endfunction

  always @(posedge clk) font_data <= glyph(font_addr);

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] c, input logic [3:0] r);
    bit ok;
    ok            = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_char  = c;
    bus.req_row   = r;
    for (int n = 0; n < 24 && !ok; n++) begin
      if (bus.req_ready) ok = 1'b1;
      tick();
    end
    bus.req_valid = 1'b0;
    chk1("send_accepted", ok, 1'b1);
  endtask

  // Expects pixel 0 of the cell to be on the outputs now; pix_ready must be high.
  task automatic expect_cell(input string tag, input logic [6:0] c, input logic [3:0] r);
    for (int i = 0; i < 8; i++) begin
      chk1({tag, "_valid"}, bus.pix_valid, 1'b1);
      chk1({tag, "_pix"}, bus.pix, exp_pix(c, r, i));
      chk1({tag, "_last"}, bus.last, (i == 7));
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    errors        = 0;
    checks        = 0;
    rstn          = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_char  = '0;
    bus.req_row   = '0;
    bus.pix_ready = 1'b1;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_pix_valid", bus.pix_valid, 1'b0);
    chk7("rst_font_addr", font_addr, 7'h00);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_pix", bus.pix, 1'b0);
    chk1("rst_last", bus.last, 1'b0);
    rstn = 1'b1;
    tick();
    chk1("rst_req_ready", bus.req_ready, 1'b1);

    // Single request: 2-cycle latency, then 8 pixels
    send(7'h41, 4'd0);
    chk1("single_ready_low", bus.req_ready, 1'b0);
    chk1("single_lat_e0", bus.pix_valid, 1'b0);
    chk7("single_addr", font_addr, 7'h41);
    tick();
    chk1("single_lat_e1", bus.pix_valid, 1'b0);
    tick();
    expect_cell("single", 7'h41, 4'd0);
    chk1("single_done_valid", bus.pix_valid, 1'b0);
    chk1("single_done_busy", busy, 1'b0);

    // Stream all 16 rows, requests offered continuously
    fork
      begin
        for (int r = 0; r < 16; r++) send(7'h41, 4'(r));
      end
      begin
        for (int n = 0; n < 10 && !bus.pix_valid; n++) tick();
        for (int i = 0; i < 128; i++) begin
          chk1("stream_valid", bus.pix_valid, 1'b1);
          chk1("stream_pix", bus.pix, exp_pix(7'h41, 4'(i / 8), i % 8));
          chk1("stream_last", bus.last, (i % 8 == 7));
          tick();
        end
      end
    join
    chk1("stream_done_valid", bus.pix_valid, 1'b0);

    // Backpressure on pixels 3-5
    send(7'h41, 4'd12);
    tick();
    tick();
    begin
      int i;
      int stalls;
      i      = 0;
      stalls = 0;
      for (int guard = 0; guard < 30 && i < 8; guard++) begin
        chk1("bp_valid", bus.pix_valid, 1'b1);
        chk1("bp_pix", bus.pix, exp_pix(7'h41, 4'd12, i));
        chk1("bp_last", bus.last, (i == 7));
        if (i >= 2 && i <= 4 && stalls < 3) begin
          bus.pix_ready = 1'b0;
          stalls++;
        end else begin
          bus.pix_ready = 1'b1;
          i++;
        end
        tick();
      end
      chk1("bp_all_pixels", (i == 8), 1'b1);
    end
    bus.pix_ready = 1'b1;
    chk1("bp_done_valid", bus.pix_valid, 1'b0);

    // Boundary: char 127 row 15, second request fills the next-buffer
    bus.pix_ready = 1'b0;
    send(7'd127, 4'd15);
    tick();
    tick();
    chk1("bnd_valid", bus.pix_valid, 1'b1);
    chk1("bnd_pix0", bus.pix, exp_pix(7'd127, 4'd15, 0));
    send(7'h41, 4'd13);
    tick();
    tick();
    bus.req_valid = 1'b1;
    bus.req_char  = 7'h22;
    bus.req_row   = 4'd0;
    chk1("bnd_ready_low", bus.req_ready, 1'b0);
    chk1("bnd_busy", busy, 1'b1);
    tick();
    chk1("bnd_ready_still_low", bus.req_ready, 1'b0);
    chk7("bnd_addr_held", font_addr, 7'h41);
    chk1("bnd_pix_held", bus.pix, exp_pix(7'd127, 4'd15, 0));
    bus.req_valid = 1'b0;
    bus.pix_ready = 1'b1;
    expect_cell("bnd_c127", 7'd127, 4'd15);
    expect_cell("bnd_nxt", 7'h41, 4'd13);
    chk1("bnd_done_valid", bus.pix_valid, 1'b0);
    chk1("bnd_done_busy", busy, 1'b0);

    // Reset mid-stream at pixel 4 with the next-buffer full
    send(7'h41, 4'd0);
    tick();
    tick();
    send(7'h41, 4'd1);
    tick();
    tick();
    tick();
    chk1("mid_pix4_valid", bus.pix_valid, 1'b1);
    chk1("mid_pix4", bus.pix, exp_pix(7'h41, 4'd0, 4));
    #3;
    rstn = 1'b0;
    #1;
    chk1("mid_rst_valid", bus.pix_valid, 1'b0);
    chk1("mid_rst_pix", bus.pix, 1'b0);
    chk1("mid_rst_last", bus.last, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk7("mid_rst_addr", font_addr, 7'h00);
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      chk1("mid_no_stale", bus.pix_valid, 1'b0);
    end
    chk1("mid_ready", bus.req_ready, 1'b1);
    send(7'h41, 4'd11);
    tick();
    tick();
    expect_cell("mid_new", 7'h41, 4'd11);
    chk1("mid_done_valid", bus.pix_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
